// File: rtl/mem_access_unit_pkg.sv
// rtl/mem_access_unit_pkg.sv - shared encodings for the load/store unit
package mem_access_unit_pkg;

  // Access width encoding on width_i; the reserved code behaves as a word.
  typedef enum logic [1:0] {
    WIDTH_BYTE = 2'b00,
    WIDTH_HALF = 2'b01,
    WIDTH_WORD = 2'b10,
    WIDTH_RSVD = 2'b11
  } width_e;

  // Write-back source select on reg_src_i.
  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_PC   = 2'b10,
    SRC_ZERO = 2'b11
  } reg_src_e;

  // Memory handshake states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/load_store_align.sv
// rtl/load_store_align.sv - alignment check, store lane steering, load extraction
module load_store_align
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rdata,
  input  logic [1:0]      i_width,
  input  logic            i_sign_ext,
  output logic            o_misaligned,
  output logic [3:0]      o_be,
  output logic [XLEN-1:0] o_wdata,
  output logic [XLEN-1:0] o_load_data
);

  logic [XLEN-1:0] w_shifted;

  // Move the addressed lane down to bit 0, then size/extend per access width.
  always_comb begin
    w_shifted    = i_rdata >> {i_addr_lo, 3'b000};
    o_misaligned = 1'b0;
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    o_load_data  = w_shifted;
    case (i_width)
      WIDTH_BYTE: begin
        o_be        = 4'b0001 << i_addr_lo;
        o_wdata     = {(XLEN/8){i_wdata[7:0]}};
        o_load_data = {{(XLEN-8){i_sign_ext & w_shifted[7]}}, w_shifted[7:0]};
      end
      WIDTH_HALF: begin
        o_misaligned = i_addr_lo[0];
        o_be         = 4'b0011 << {i_addr_lo[1], 1'b0};
        o_wdata      = {(XLEN/16){i_wdata[15:0]}};
        o_load_data  = {{(XLEN-16){i_sign_ext & w_shifted[15]}}, w_shifted[15:0]};
      end
      default: begin
        o_misaligned = |i_addr_lo;
      end
    endcase
    if (o_misaligned) begin
      o_load_data = '0;
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM stage: memory handshake FSM and write-back select
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  input  logic [1:0]      width_i,
  input  logic            sign_ext_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic [1:0]      reg_src_i,
  input  logic [XLEN-1:0] advance_pc_i,
  input  logic [4:0]      reg_addr_i,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  output logic [3:0]      mem_be_o,
  input  logic            mem_ack_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            mem_stall_o,
  output logic [XLEN-1:0] write_back_o,
  output logic [4:0]      write_addr_o,
  output logic            misaligned_o
);

  state_e          r_state;
  state_e          w_next;
  logic [XLEN-1:0] r_rdata;
  logic            w_access;
  logic            w_misaligned;
  logic            w_req;
  logic            w_mis_pulse;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic [XLEN-1:0] w_load_data;

  assign w_access = mem_read_i | mem_write_i;

  load_store_align #(.XLEN(XLEN)) u_align (
    .i_addr_lo    (addr_i[1:0]),
    .i_wdata      (wdata_i),
    .i_rdata      (r_rdata),
    .i_width      (width_i),
    .i_sign_ext   (sign_ext_i),
    .o_misaligned (w_misaligned),
    .o_be         (w_be),
    .o_wdata      (w_wdata),
    .o_load_data  (w_load_data)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture read data only on the acknowledged WAIT cycle; acks elsewhere are stray.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (r_state == ST_WAIT && mem_ack_i) begin
      r_rdata <= mem_rdata_i;
    end
  end

  // Next state and handshake; a misaligned access never leaves IDLE.
  always_comb begin
    w_next      = r_state;
    w_req       = 1'b0;
    w_mis_pulse = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_access) begin
          if (w_misaligned) begin
            w_mis_pulse = 1'b1;
          end else begin
            w_req  = 1'b1;
            w_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        w_req = 1'b1;
        if (mem_ack_i) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are gated by rst so a request drops the instant reset asserts.
  always_comb begin
    mem_req_o    = w_req & ~rst;
    mem_stall_o  = w_req & ~rst;
    mem_we_o     = w_req & ~rst & mem_write_i;
    mem_be_o     = (w_req & ~rst) ? w_be : 4'b0000;
    misaligned_o = w_mis_pulse & ~rst;
    mem_addr_o   = {addr_i[XLEN-1:2], 2'b00};
    mem_wdata_o  = w_wdata;
    write_addr_o = reg_addr_i;
    case (reg_src_i)
      SRC_ALU:  write_back_o = addr_i;
      SRC_LOAD: write_back_o = w_load_data;
      SRC_PC:   write_back_o = advance_pc_i;
      default:  write_back_o = '0;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized and directed bench for mem_access_unit
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  width_i;
  logic        sign_ext_i;
  logic        mem_read_i;
  logic        mem_write_i;
  logic [1:0]  reg_src_i;
  logic [31:0] advance_pc_i;
  logic [4:0]  reg_addr_i;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        mem_stall_o;
  logic [31:0] write_back_o;
  logic [4:0]  write_addr_o;
  logic        misaligned_o;

  int checks   = 0;
  int failures = 0;

  int          obs_stall;
  int          obs_req;
  int          obs_mis;
  logic [31:0] obs_wb;
  logic [31:0] obs_addr;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata;

  mem_access_unit #(.XLEN(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .width_i      (width_i),
    .sign_ext_i   (sign_ext_i),
    .mem_read_i   (mem_read_i),
    .mem_write_i  (mem_write_i),
    .reg_src_i    (reg_src_i),
    .advance_pc_i (advance_pc_i),
    .reg_addr_i   (reg_addr_i),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_be_o     (mem_be_o),
    .mem_ack_i    (mem_ack_i),
    .mem_rdata_i  (mem_rdata_i),
    .mem_stall_o  (mem_stall_o),
    .write_back_o (write_back_o),
    .write_addr_o (write_addr_o),
    .misaligned_o (misaligned_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  function automatic logic m_mis(input logic [31:0] a, input logic [1:0] w);
    if (w == 2'd0) return 1'b0;
    if (w == 2'd1) return a[0];
    return a[1:0] != 2'd0;
  endfunction

  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] w);
    if (w == 2'd0) return 4'b0001 << a[1:0];
    if (w == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input logic [1:0] w);
    if (w == 2'd0) return {24'd0, wd[7:0]} * 32'h0101_0101;
    if (w == 2'd1) return {16'd0, wd[15:0]} * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [1:0] w, input logic se);
    logic [31:0] v;
    int lane;
    lane = int'(a[1:0]);
    if (m_mis(a, w)) return 32'd0;
    if (w == 2'd0) begin
      v = (rd / (32'd1 << (8 * lane))) % 32'd256;
      if (se && v >= 32'd128) v = v + 32'hFFFF_FF00;
    end else if (w == 2'd1) begin
      v = (rd / (32'd1 << (8 * lane))) % 32'd65536;
      if (se && v >= 32'd32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [31:0] m_wb(input logic [1:0] src, input logic [31:0] a,
                                       input logic [31:0] ld, input logic [31:0] pc);
    case (src)
      2'd0:    return a;
      2'd1:    return ld;
      2'd2:    return pc;
      default: return 32'd0;
    endcase
  endfunction

  // One pipeline instruction in MEM: holds inputs until the stage would advance.
  // Ack arrives k cycles after the request; an aligned access stalls k+1 cycles.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] w, input logic se,
                         input logic [1:0] src, input logic [31:0] pc,
                         input logic [4:0] ra, input int k, input logic [31:0] rdata);
    logic access;
    logic mis;
    logic aligned;
    logic busy;
    logic [31:0] ld;
    int len;
    addr_i = a; wdata_i = wd; width_i = w; sign_ext_i = se;
    mem_read_i = rd; mem_write_i = wr; reg_src_i = src;
    advance_pc_i = pc; reg_addr_i = ra;
    access  = rd | wr;
    mis     = access && m_mis(a, w);
    aligned = access && !mis;
    len     = aligned ? k + 2 : 1;
    ld      = (rd && !wr) ? m_load(rdata, a, w, se) : 32'd0;
    obs_stall = 0; obs_req = 0; obs_mis = 0;
    obs_wb = '0; obs_addr = '0; obs_be = '0; obs_wdata = '0;
    for (int c = 0; c < len; c++) begin
      if (aligned && c == k) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = rdata;
      end else begin
        mem_ack_i   = (c == k + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata_i = $urandom;
      end
      @(negedge clk);
      busy = aligned && (c <= k);
      chk("stall", {31'd0, mem_stall_o}, {31'd0, busy});
      chk("req", {31'd0, mem_req_o}, {31'd0, busy});
      chk("we", {31'd0, mem_we_o}, {31'd0, busy && wr});
      chk("misaligned", {31'd0, misaligned_o}, {31'd0, mis});
      chk("write_addr", {27'd0, write_addr_o}, {27'd0, ra});
      if (busy) begin
        chk("mem_addr", mem_addr_o, a & 32'hFFFF_FFFC);
        if (wr) begin
          chk("be", {28'd0, mem_be_o}, {28'd0, m_be(a, w)});
          chk("mem_wdata", mem_wdata_o, m_wdata(wd, w));
        end
      end else begin
        chk("be_idle", {28'd0, mem_be_o}, 32'd0);
        chk("write_back", write_back_o, m_wb(src, a, ld, pc));
      end
      if (mem_stall_o) obs_stall++;
      if (mem_req_o) begin
        obs_req++;
        obs_addr  = mem_addr_o;
        obs_be    = mem_be_o;
        obs_wdata = mem_wdata_o;
      end
      if (misaligned_o) obs_mis++;
      obs_wb = write_back_o;
      @(posedge clk);
      #1;
    end
    mem_ack_i = 1'b0;
  endtask

  initial begin
    logic rd, wr;
    logic [1:0] w, src;
    rst = 1'b1;
    addr_i = 32'h10; wdata_i = 32'hFFFF_FFFF; width_i = 2'd2; sign_ext_i = 1'b0;
    mem_read_i = 1'b0; mem_write_i = 1'b1; reg_src_i = 2'd1;
    advance_pc_i = 32'd0; reg_addr_i = 5'd7; mem_ack_i = 1'b1; mem_rdata_i = 32'hFFFF_FFFF;

    // Reset holds every control output low even with a store and an ack present.
    @(negedge clk);
    chk("rst_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_stall", {31'd0, mem_stall_o}, 32'd0);
    chk("rst_be", {28'd0, mem_be_o}, 32'd0);
    addr_i = 32'h13; mem_write_i = 1'b0; mem_read_i = 1'b1;
    #1;
    chk("rst_misaligned", {31'd0, misaligned_o}, 32'd0);
    mem_read_i = 1'b0;
    #1;
    chk("rst_capture_zero", write_back_o, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_ack_i = 1'b0;

    // Byte load with sign extension, ack after two cycles.
    run_txn(1, 0, 32'h103, 32'h0, 2'd0, 1, 2'd1, 32'h0, 5'd3, 2, 32'h80FF_0000);
    chk("lb_stall_len", obs_stall, 32'd3);
    chk("lb_data", obs_wb, 32'hFFFF_FF80);

    // Half store to the upper lane.
    run_txn(0, 1, 32'h202, 32'h1234_ABCD, 2'd1, 0, 2'd0, 32'h0, 5'd4, 1, 32'h0);
    chk("sh_addr", obs_addr, 32'h200);
    chk("sh_be", {28'd0, obs_be}, 32'hC);
    chk("sh_wdata", obs_wdata, 32'hABCD_ABCD);
    chk("sh_stall_len", obs_stall, 32'd2);

    // Misaligned word load.
    run_txn(1, 0, 32'h305, 32'h0, 2'd2, 0, 2'd1, 32'h0, 5'd5, 1, 32'h1111_1111);
    chk("mis_pulse", obs_mis, 32'd1);
    chk("mis_req", obs_req, 32'd0);
    chk("mis_stall", obs_stall, 32'd0);
    chk("mis_data", obs_wb, 32'd0);

    // Non-memory instruction returning advance_pc.
    run_txn(0, 0, 32'h9000, 32'h0, 2'd2, 0, 2'd2, 32'h44, 5'd6, 1, 32'h0);
    chk("pc_wb", obs_wb, 32'h44);
    chk("pc_stall", obs_stall, 32'd0);

    // Back-to-back loads.
    run_txn(1, 0, 32'h400, 32'h0, 2'd2, 0, 2'd1, 32'h0, 5'd8, 1, 32'h1122_3344);
    chk("b2b0_data", obs_wb, 32'h1122_3344);
    chk("b2b0_stall", obs_stall, 32'd2);
    run_txn(1, 0, 32'h402, 32'h0, 2'd1, 1, 2'd1, 32'h0, 5'd9, 1, 32'h8001_0000);
    chk("b2b1_data", obs_wb, 32'hFFFF_8001);
    chk("b2b1_stall", obs_stall, 32'd2);

    // Reset while waiting: request drops at once, later acks do nothing.
    addr_i = 32'h500; width_i = 2'd2; mem_read_i = 1'b1; mem_write_i = 1'b0;
    reg_src_i = 2'd1; mem_ack_i = 1'b0;
    @(negedge clk);
    chk("rw_req_idle", {31'd0, mem_req_o}, 32'd1);
    @(posedge clk); #1;
    chk("rw_req_wait", {31'd0, mem_req_o}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rw_req_drop", {31'd0, mem_req_o}, 32'd0);
    chk("rw_stall_drop", {31'd0, mem_stall_o}, 32'd0);
    mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rw_req_held", {31'd0, mem_req_o}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; mem_read_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rw_post_stall", {31'd0, mem_stall_o}, 32'd0);
      chk("rw_post_wb", write_back_o, 32'd0);
      @(posedge clk); #1;
    end
    mem_ack_i = 1'b0;
    run_txn(1, 0, 32'h600, 32'h0, 2'd2, 0, 2'd1, 32'h0, 5'd10, 1, 32'hCAFE_F00D);
    chk("rw_next_data", obs_wb, 32'hCAFE_F00D);

    // Randomized instruction stream.
    for (int n = 0; n < 80; n++) begin
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 3) == 0);
      w  = 2'($urandom_range(0, 3));
      if (rd && !wr) src = 2'($urandom_range(0, 3));
      else begin
        src = 2'($urandom_range(0, 2));
        if (src == 2'd1) src = 2'd3;
      end
      run_txn(rd, wr, $urandom, $urandom, w, 1'($urandom_range(0, 1)), src,
              $urandom, 5'($urandom_range(0, 31)), $urandom_range(1, 4), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath and address width.
REQ-002 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port addr_i, input, XLEN: effective address and ALU result from the EX/MEM register.
REQ-005 SHALL have port wdata_i, input, XLEN: store data (rs2).
REQ-006 SHALL have port width_i, input, 2: 00 byte, 01 half, 10 word, 11 reserved (treated as word).
REQ-007 SHALL have ports sign_ext_i, mem_read_i and mem_write_i, input, 1 each: load sign-extend, load request, store request.
REQ-008 SHALL have port reg_src_i, input, 2: write-back source; 00 ALU, 01 load, 10 advance_pc, 11 zero.
REQ-009 SHALL have ports advance_pc_i, input, XLEN, and reg_addr_i, input, 5.
REQ-010 SHALL have memory-side ports: mem_req_o 1, mem_we_o 1, mem_addr_o XLEN (word-aligned), mem_wdata_o XLEN, mem_be_o 4 (all outputs); mem_ack_i 1 and mem_rdata_i XLEN (inputs).
REQ-011 SHALL have outputs mem_stall_o 1, write_back_o XLEN, write_addr_o 5 and misaligned_o 1.

Function
REQ-012 SHALL implement FSM IDLE/WAIT/DONE; an access is present when mem_read_i or mem_write_i is 1; if both are 1, the access is a store.
REQ-013 In IDLE with an aligned access present, mem_req_o and mem_stall_o SHALL be 1 combinationally that cycle (T), and the next state SHALL be WAIT.
REQ-014 In WAIT, mem_req_o and mem_stall_o SHALL stay 1 with stable addr/data/be; on mem_ack_i=1 at T+k (k>=1), mem_rdata_i SHALL be captured and the next state SHALL be DONE.
REQ-015 In DONE, mem_stall_o and mem_req_o SHALL be 0, write_back_o SHALL use the captured data, and the next state SHALL be IDLE unconditionally; stall length is exactly k+1 cycles.
REQ-016 mem_ack_i SHALL be ignored outside WAIT.
REQ-017 Misalignment: half access with addr[0]=1, or word access with addr[1:0]!=0.
REQ-018 A misaligned access SHALL issue no request, raise no stall, pulse misaligned_o=1 for that cycle, and produce load data of 0.
REQ-019 mem_addr_o SHALL equal addr_i with bits [1:0] forced to 0.
REQ-020 mem_we_o SHALL equal 1 for stores only.
REQ-021 Store byte enables: byte 0001<<addr[1:0]; half 0011<<(2*addr[1]); word 1111.
REQ-022 mem_wdata_o SHALL be the byte replicated x4, the half replicated x2, or the full word.
REQ-023 Load data SHALL be mem_rdata shifted right by 8*addr[1:0], truncated to width, then zero- or sign-extended per sign_ext_i.
REQ-024 write_back_o SHALL select per reg_src_i: addr_i, load data, advance_pc_i or 0; write_addr_o SHALL equal reg_addr_i combinationally.
REQ-025 Non-memory cycles SHALL hold the FSM in IDLE, with write_back_o valid the same cycle and no stall.

Reset
REQ-026 While rst=1 the FSM SHALL be IDLE, the capture register 0, and mem_req_o, mem_we_o, mem_stall_o, misaligned_o and mem_be_o 0, regardless of other inputs.
REQ-027 Reset in WAIT SHALL drop mem_req_o immediately, and any later ack SHALL be ignored.

Structure
REQ-028 A shared package SHALL hold the width_i encodings, reg_src_i encodings and the FSM state enum.
REQ-029 Alignment, byte-enable and extension logic SHALL be a combinational sub-module load_store_align; FSM and capture register stay in mem_access_unit.

Verification
REQ-030 Load byte: addr=0x103, sign_ext=1, reg_src=01, ack at k=2 with rdata=0x80FF_0000 -> stall 3 cycles, write_back_o=0xFFFF_FF80.
REQ-031 Store half: addr=0x202, wdata=0x1234_ABCD, ack k=1 -> mem_addr_o=0x200, be=1100, wdata=0xABCD_ABCD, stall 2 cycles.
REQ-032 Load word at addr 0x305 -> misaligned_o=1 one cycle, mem_req_o=0, stall 0.
REQ-033 reg_src=10, advance_pc_i=0x44, no access -> write_back_o=0x44 the same cycle, stall 0.
REQ-034 rst=1 in WAIT, then ack one cycle later -> mem_req_o=0 at once, FSM IDLE, no DONE cycle.
REQ-035 Back-to-back loads, each ack k=1 -> two 2-cycle stalls separated by one DONE cycle, correct data each.
